// File: rtl/ram_master.sv
// ram_master: byte/half/word load-store controller for a word-only RAM port.
// Sub-word stores are done as read-modify-write; one response per request.
module ram_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              acc_err;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] st_word;

    // Misalignment / illegal size check on the incoming request
    always_comb begin
        acc_err = 1'b0;
        case (req_size_i)
            SZ_BYTE: acc_err = 1'b0;
            SZ_HALF: acc_err = req_addr_i[0];
            SZ_WORD: acc_err = (req_addr_i[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
    end

    // Lane select and sign/zero extension of the word being read
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = ram_data_i[7:0];
            2'd1:    ld_byte = ram_data_i[15:8];
            2'd2:    ld_byte = ram_data_i[23:16];
            default: ld_byte = ram_data_i[31:24];
        endcase
        ld_half = addr_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
        case (size_q)
            SZ_BYTE: ld_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            SZ_HALF: ld_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_val = ram_data_i;
        endcase
    end

    // Merge store data into the word captured during RD
    always_comb begin
        st_word = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    st_word[7:0]   = wdata_q[7:0];
                    2'd1:    st_word[15:8]  = wdata_q[7:0];
                    2'd2:    st_word[23:16] = wdata_q[7:0];
                    default: st_word[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1]) st_word[31:16] = wdata_q[15:0];
                else           st_word[15:0]  = wdata_q[15:0];
            end
            default: st_word = wdata_q;
        endcase
    end

    // RAM port and handshake outputs decoded from the current state
    always_comb begin
        req_ready_o  = (state == S_IDLE);
        resp_valid_o = (state == S_RESP);
        ram_wr_en_o  = (state == S_WR);
        ram_addr_o   = '0;
        ram_data_o   = '0;
        if (state == S_RD || state == S_WR)
            ram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
        if (state == S_WR)
            ram_data_o = st_word;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
    end

    // Request capture, sequencing and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        size_q  <= req_size_i;
                        we_q    <= req_we_i;
                        uns_q   <= req_unsigned_i;
                        if (acc_err) begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end else if (req_we_i && req_size_i == SZ_WORD) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    word_q <= ram_data_i;
                    if (we_q) begin
                        state <= S_WR;
                    end else begin
                        rdata_q <= ld_val;
                        state   <= S_RESP;
                    end
                end
                S_WR: state <= S_RESP;
                default: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized and directed checks of ram_master against a
// byte-addressed reference memory model.
module tb_ram_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_uns;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_wr_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Word RAM seen by the DUT
    logic [31:0] mem [0:63];
    // Reference memory, byte addressed, little-endian
    logic [7:0]  ref_bytes [0:255];

    ram_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .ram_wr_en_o    (ram_wr_en),
        .ram_addr_o     (ram_addr),
        .ram_data_o     (ram_wdata),
        .ram_data_i     (ram_rdata)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[7:2]];

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr[7:2]] <= ram_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request: error rules, little-endian access,
    // extension, and the latency/write count each request class should show.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int wrs);
        int nbytes;
        int base;
        logic [31:0] v;
        err   = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        rdata = 32'h0;
        wrs   = 0;
        if (err) begin
            lat = 1;
            return;
        end
        nbytes = 1 << size;
        base   = int'(addr[7:0]);
        if (we) begin
            for (int k = 0; k < nbytes; k++) ref_bytes[base + k] = 8'(wdata >> (8 * k));
            lat = (size == 2'd2) ? 2 : 3;
            wrs = 1;
        end else begin
            v = 32'h0;
            for (int k = 0; k < nbytes; k++) v = v | (32'(ref_bytes[base + k]) << (8 * k));
            if (!uns && nbytes < 4 && v[8 * nbytes - 1])
                v = v | ~((32'h1 << (8 * nbytes)) - 32'h1);
            rdata = v;
            lat   = 2;
        end
    endtask

    // Issue one request in the next IDLE cycle and check its response
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input bit hold);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_wr;
        int          lat;
        int          wr_cnt;
        bit          got;
        @(negedge clk);
        check_eq("ready_in_idle", 32'(req_ready), 32'd1);
        check_eq("resp_one_cycle", 32'(resp_valid), 32'd0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_uns   = uns;
        @(posedge clk);
        model(we, addr, wdata, size, uns, exp_err, exp_rd, exp_lat, exp_wr);
        #1;
        if (!hold) req_valid = 1'b0;
        lat    = 0;
        wr_cnt = 0;
        got    = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (ram_wr_en) wr_cnt++;
            check_eq("ram_addr_align", 32'(ram_addr[1:0]), 32'd0);
            if (resp_valid) begin
                got = 1'b1;
                check_eq("latency", 32'(lat), 32'(exp_lat));
                check_eq("resp_err", 32'(resp_err), 32'(exp_err));
                check_eq("resp_rdata", resp_rdata, exp_rd);
            end else begin
                check_eq("ready_busy", 32'(req_ready), 32'd0);
                check_eq("rdata_idle_zero", resp_rdata, 32'd0);
                check_eq("err_idle_zero", 32'(resp_err), 32'd0);
            end
        end
        if (!got) check_eq("resp_timeout", 32'd0, 32'd1);
        check_eq("wr_pulses", 32'(wr_cnt), 32'(exp_wr));
    endtask

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        req_uns   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int k = 0; k < 4; k++) ref_bytes[4 * i + k] = 8'(w >> (8 * k));
        end

        #12;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_ram_addr", ram_addr, 32'd0);
        check_eq("rst_ram_data", ram_wdata, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);

        // Word store then load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);

        // Byte RMW into a known word
        do_req(1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 1'b0);
        do_req(1'b1, 32'h21, 32'h000000AA, 2'd0, 1'b0, 1'b0);
        do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0);
        check_eq("rmw_byte_mem", mem[8], 32'h1122AA44);

        // Sign/zero extension
        do_req(1'b1, 32'h30, 32'h8000F0FF, 2'd2, 1'b0, 1'b0);
        do_req(1'b0, 32'h30, 32'h0, 2'd0, 1'b0, 1'b0);
        do_req(1'b0, 32'h30, 32'h0, 2'd0, 1'b1, 1'b0);
        do_req(1'b0, 32'h32, 32'h0, 2'd1, 1'b0, 1'b0);
        do_req(1'b0, 32'h32, 32'h0, 2'd1, 1'b1, 1'b0);

        // Error cases
        do_req(1'b0, 32'h41, 32'h0, 2'd1, 1'b0, 1'b0);
        do_req(1'b1, 32'h42, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0);
        do_req(1'b1, 32'h40, 32'h12345678, 2'd3, 1'b0, 1'b0);
        do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 1'b0);

        // Reset during the WR cycle of a half store at 0x50
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h52;
        req_wdata = 32'h0000BEEF;
        req_size  = 2'd1;
        req_uns   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("wr_before_rst", 32'(ram_wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_async_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_async_addr", ram_addr, 32'd0);
        check_eq("rst_async_data", ram_wdata, 32'd0);
        check_eq("rst_async_resp", 32'(resp_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h50, 32'h0, 2'd2, 1'b0, 1'b0);

        // Continuous valid, alternating store/load
        for (int i = 0; i < 8; i++) begin
            a = {24'h0, 2'b01, 4'(i), 2'b00};
            if (i % 2 == 0) do_req(1'b1, a, $urandom, 2'd2, 1'b0, 1'b1);
            else            do_req(1'b0, a - 32'd4, 32'h0, 2'd2, 1'b0, 1'b1);
        end
        req_valid = 1'b0;

        // Randomized mix, mostly aligned
        for (int i = 0; i < 150; i++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            w = {ref_bytes[4 * i + 3], ref_bytes[4 * i + 2], ref_bytes[4 * i + 1], ref_bytes[4 * i]};
            check_eq("final_mem", mem[i], w);
        end
        check_eq("ram_addr_hi_zero", 32'(ram_addr[31:8]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_master.md
# ram_master

Initiator-side access controller driving the word-only data RAM port: write enable, word address, write data and combinational read data, with writes committed on the clock edge. Accepts byte/halfword/word load and store requests from the core's memory stage over a valid/ready handshake and returns one response per request. Sub-word stores are done as a read-modify-write, so the RAM itself stays word-granular.

## Interface
Parameters:
- ADDR_W, 32, request/RAM address width.
- DATA_W, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  32  load result (0 for stores/errors).
- resp_err_o  out  1  misaligned or illegal size; no RAM access made.
- ram_wr_en_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address, always word-aligned ([1:0]=00).
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data, combinational from ram_addr_o.

## Operation
- Request accepted on rising edge where req_valid_i & req_ready_o; addr, wdata, size, we, unsigned latched.
- Error check at acceptance: size 11, half with addr[0]=1, word with addr[1:0]≠00 → go to RESP with resp_err_o=1, no RAM cycle.
- States: IDLE, RD, WR, RESP.
  - IDLE: req_ready_o=1, ram_wr_en_o=0, ram_addr_o=0, ram_data_o=0. Accept → error: RESP; load: RD; word store: WR; byte/half store: RD.
  - RD: ram_addr_o={addr[ADDR_W-1:2],2'b00}, ram_wr_en_o=0; ram_data_i captured into word register at edge. Load → RESP; store → WR.
  - WR: ram_addr_o as in RD, ram_wr_en_o=1, ram_data_o=merged word → RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, resp_rdata_o/resp_err_o valid → IDLE. No response backpressure.
- Load extract: byte lane addr[1:0] (lane 0 = bits [7:0]); half lane addr[1] (0 = [15:0]); word as-is. Extend per req_unsigned_i; word ignores it.
- Store merge: byte writes wdata[7:0] into lane addr[1:0]; half writes wdata[15:0] into lane addr[1]; other lanes keep the word read in RD. Word store writes wdata directly, no read.
- resp_rdata_o, resp_err_o registered; hold value only during RESP, 0 otherwise.

## Timing
- Acceptance edge T. Load: RD cycle T..T+1, resp_valid_o high cycle after T+1 (latency 2). Word store: WR then RESP (latency 2). Sub-word store: RD, WR, RESP (latency 3). Error: RESP immediately (latency 1).
- RAM write commits on the edge ending the WR cycle; a load accepted right after RESP reads the new data.
- req_ready_o low from acceptance until return to IDLE; back-to-back requests: next acceptance in the cycle after RESP.
- Reset (async, any state): state→IDLE immediately; ram_wr_en_o=0, ram_addr_o=0, ram_data_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, req_ready_o=1 after release. In-flight request is dropped: no write, no response.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → store resp at latency 2, err=0; load resp_rdata_o=0xDEADBEEF at latency 2; ram_wr_en_o high exactly one cycle.
- Over word 0x11223344 @0x20: byte store 0xAA @0x21, then word load → 0x1122AA44; RD/WR/RESP sequence, latency 3.
- Word 0x8000F0FF @0x30: signed byte load @0x30 → 0xFFFFFFFF; unsigned → 0x000000FF; signed half @0x32 → 0xFFFF8000; unsigned half @0x32 → 0x00008000.
- Half load @0x41, word store @0x42, size 11 → resp_err_o=1 at latency 1, rdata 0, ram_wr_en_o never high, RAM contents unchanged.
- Assert rst during WR cycle of a sub-word store → ram_wr_en_o drops asynchronously, no RAM change, no resp_valid_o; after release req_ready_o=1 and next load succeeds.
- Continuous req_valid_i with 8 alternating stores/loads → exactly 8 resp pulses, in order, req_ready_o only in IDLE cycles.
